data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Single-port data memory controller for a core data port.
//               Each accepted load or store takes a fixed number of wait
//               states, then completes with a one-cycle valid pulse.
//               Byte-lane masked stores. Out-of-range accesses are flagged
//               on addr_error.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        addr_error
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;

  // Access captured at acceptance; inputs are not looked at again afterwards.
  logic            r_we;
  logic [3:0]      r_mask;
  logic [31:0]     r_wdata;
  logic [AW-1:0]   r_idx;
  logic            r_oor;

  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic [AW-1:0]   w_in_idx;
  logic            w_in_oor;
  logic            w_acc_we;
  logic [3:0]      w_acc_mask;
  logic [31:0]     w_acc_wdata;
  logic [AW-1:0]   w_acc_idx;
  logic            w_acc_oor;
  logic            w_unused;

  // Byte offset bits never select anything; lanes come from the mask alone.
  assign w_unused = ^address[1:0];

  assign w_in_idx = address[AW+1:2];
  assign w_in_oor = (address >> (AW + 2)) != 32'd0;
  assign w_accept = (r_state == IDLE) && request;

  // With zero wait states the commit edge is the acceptance edge itself, so
  // the live inputs must be used; otherwise the captured copy is used.
  assign w_acc_we    = (r_state == IDLE) ? we_re      : r_we;
  assign w_acc_mask  = (r_state == IDLE) ? mask       : r_mask;
  assign w_acc_wdata = (r_state == IDLE) ? store_data : r_wdata;
  assign w_acc_idx   = (r_state == IDLE) ? w_in_idx   : r_idx;
  assign w_acc_oor   = (r_state == IDLE) ? w_in_oor   : r_oor;

  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

  assign valid      = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign addr_error = (r_state == RESP) && r_oor;

  // Next-state selection for the access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (request) begin
          w_next = (C_WAIT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait-state down-counter, loaded on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= C_WAIT;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture the access attributes on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_mask  <= 4'd0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we_re;
      r_mask  <= mask;
      r_wdata <= store_data;
      r_idx   <= w_in_idx;
      r_oor   <= w_in_oor;
    end
  end

  // Store commit on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_acc_we && !w_acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_mask[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Load result captured on the edge entering RESP and held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data <= 32'd0;
    end else if (w_enter_resp && !w_acc_we) begin
      load_data <= w_acc_oor ? 32'd0 : r_mem[w_acc_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl. One instance
//               with one wait state, one with zero wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_a, we_a;
  logic [3:0]  mask_a;
  logic [31:0] addr_a, sd_a;
  logic        valid_a, busy_a, aerr_a;
  logic [31:0] ld_a;

  logic        req_b, we_b;
  logic [3:0]  mask_b;
  logic [31:0] addr_b, sd_b;
  logic        valid_b, busy_b, aerr_b;
  logic [31:0] ld_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .request(req_a), .we_re(we_a), .mask(mask_a),
    .address(addr_a), .store_data(sd_a), .valid(valid_a), .load_data(ld_a),
    .busy(busy_a), .addr_error(aerr_a)
  );

  data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req_b), .we_re(we_b), .mask(mask_b),
    .address(addr_b), .store_data(sd_b), .valid(valid_b), .load_data(ld_b),
    .busy(busy_b), .addr_error(aerr_b)
  );

  // Issue one access from idle, scramble the inputs after acceptance and
  // wait (bounded) for valid. lat = cycles from acceptance edge to valid.
  task automatic access(input bit sel, input logic we, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] ld,
                        output logic aerr, output logic bsy);
    if (!sel) begin req_a = 1'b1; we_a = we; mask_a = m; addr_a = a; sd_a = d; end
    else      begin req_b = 1'b1; we_b = we; mask_b = m; addr_b = a; sd_b = d; end
    @(posedge clk); #1;
    if (!sel) begin req_a = 1'b0; we_a = ~we; mask_a = 4'hF; addr_a = 32'hFFFF_FFFC; sd_a = ~d; end
    else      begin req_b = 1'b0; we_b = ~we; mask_b = 4'hF; addr_b = 32'hFFFF_FFFC; sd_b = ~d; end
    lat = 1;
    bsy = sel ? busy_b : busy_a;
    while (!(sel ? valid_b : valid_a) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ld   = sel ? ld_b : ld_a;
    aerr = sel ? aerr_b : aerr_a;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 1'b1; we_a = 1'b0; mask_a = 4'hF; addr_a = 32'h10; sd_a = 32'h0;
    req_b = 1'b1; we_b = 1'b0; mask_b = 4'hF; addr_b = 32'h10; sd_b = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_req_held got=%b exp=0", busy_a); end
    checks++; if (aerr_a !== 1'b0) begin failures++; $display("FAIL reset_addr_error got=%b exp=0", aerr_a); end
    checks++; if (ld_a !== 32'h0) begin failures++; $display("FAIL reset_load_data got=%h exp=00000000", ld_a); end
    checks++; if (busy_b !== 1'b0 || ld_b !== 32'h0) begin failures++; $display("FAIL reset_w0 busy=%b ld=%h exp busy=0 ld=0", busy_b, ld_b); end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_no_accept got busy=%b exp=0", busy_a); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] ld; logic ae, bs;
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, ld, ae, bs);
    checks++; if (lat !== 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", lat); end
    checks++; if (ae !== 1'b0 || bs !== 1'b1) begin failures++; $display("FAIL store_flags aerr=%b busy=%b exp aerr=0 busy=1", ae, bs); end
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, ld, ae, bs);
    checks++; if (lat !== 2) begin failures++; $display("FAIL load_latency got=%0d exp=2", lat); end
    checks++; if (ld !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", ld); end
    checks++; if (ae !== 1'b0) begin failures++; $display("FAIL load_addr_error got=%b exp=0", ae); end
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] ld; logic ae, bs;
    access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, lat, ld, ae, bs);
    access(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, ld, ae, bs);
    access(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, ld, ae, bs);
    checks++; if (ld !== 32'h11BB33DD) begin failures++; $display("FAIL byte_mask got=%h exp=11bb33dd", ld); end
    access(0, 1'b1, 4'hF, 32'h30, 32'h01020304, lat, ld, ae, bs);
    checks++; if (ld_a !== 32'h11BB33DD) begin failures++; $display("FAIL load_data_hold got=%h exp=11bb33dd", ld_a); end
    access(0, 1'b0, 4'h0, 32'h23, 32'h0, lat, ld, ae, bs);
    checks++; if (ld !== 32'h11BB33DD) begin failures++; $display("FAIL low_addr_bits got=%h exp=11bb33dd", ld); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] ld; logic ae, bs;
    access(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, lat, ld, ae, bs);
    access(0, 1'b0, 4'h0, 32'h1000, 32'h0, lat, ld, ae, bs);
    checks++; if (lat !== 2 || ae !== 1'b1) begin failures++; $display("FAIL oor_load lat=%0d aerr=%b exp lat=2 aerr=1", lat, ae); end
    checks++; if (ld !== 32'h0) begin failures++; $display("FAIL oor_load_data got=%h exp=00000000", ld); end
    checks++; if (aerr_a !== 1'b0) begin failures++; $display("FAIL oor_aerr_idle got=%b exp=0", aerr_a); end
    access(0, 1'b1, 4'hF, 32'h1000, 32'h12345678, lat, ld, ae, bs);
    checks++; if (ae !== 1'b1) begin failures++; $display("FAIL oor_store_aerr got=%b exp=1", ae); end
    access(0, 1'b0, 4'h0, 32'h0, 32'h0, lat, ld, ae, bs);
    checks++; if (ld !== 32'hCAFEF00D || ae !== 1'b0) begin failures++; $display("FAIL oor_store_suppressed ld=%h aerr=%b exp ld=cafef00d aerr=0", ld, ae); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bv, vv, ev;
    logic [31:0] ld5;
    bv = '0; vv = '0; ev = '0; ld5 = '0;
    req_a = 1'b1; we_a = 1'b0; mask_a = 4'hF; addr_a = 32'h10; sd_a = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      bv[k] = busy_a; vv[k] = valid_a; ev[k] = aerr_a;
      if (k == 5) ld5 = ld_a;
    end
    req_a = 1'b0;
    checks++; if (bv[6:1] !== 6'b011011) begin failures++; $display("FAIL b2b_busy cycles6..1 got=%b exp=011011", bv[6:1]); end
    checks++; if (vv[6:1] !== 6'b010010) begin failures++; $display("FAIL b2b_valid cycles6..1 got=%b exp=010010", vv[6:1]); end
    checks++; if (ev[6:1] !== 6'b000000) begin failures++; $display("FAIL b2b_aerr cycles6..1 got=%b exp=000000", ev[6:1]); end
    checks++; if (ld5 !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_load_data got=%h exp=deadbeef", ld5); end
    for (int k = 0; k < 10; k++) begin
      if (!busy_a) break;
      @(posedge clk); #1;
    end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_drain busy=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] ld; logic ae, bs; logic seen;
    access(0, 1'b1, 4'hF, 32'h40, 32'h0, lat, ld, ae, bs);
    req_a = 1'b1; we_a = 1'b1; mask_a = 4'hF; addr_a = 32'h40; sd_a = 32'h55555555;
    @(posedge clk); #1;
    req_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midrst_in_wait busy=%b exp=1", busy_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL midrst_abort valid=%b busy=%b exp 0 0", valid_a, busy_a); end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (valid_a) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_late_valid got=%b exp=0", seen); end
    access(0, 1'b0, 4'h0, 32'h40, 32'h0, lat, ld, ae, bs);
    checks++; if (ld !== 32'h0) begin failures++; $display("FAIL midrst_no_commit got=%h exp=00000000", ld); end
  endtask

  task automatic test_wait0();
    int lat; logic [31:0] ld; logic ae, bs;
    access(1, 1'b1, 4'hF, 32'h8, 32'h0BADCAFE, lat, ld, ae, bs);
    checks++; if (lat !== 1 || bs !== 1'b1) begin failures++; $display("FAIL w0_store lat=%0d busy=%b exp lat=1 busy=1", lat, bs); end
    access(1, 1'b0, 4'h0, 32'h8, 32'h0, lat, ld, ae, bs);
    checks++; if (lat !== 1 || ld !== 32'h0BADCAFE) begin failures++; $display("FAIL w0_load lat=%0d ld=%h exp lat=1 ld=0badcafe", lat, ld); end
    access(1, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF, lat, ld, ae, bs);
    checks++; if (lat !== 1 || ae !== 1'b0) begin failures++; $display("FAIL w0_mask0_store lat=%0d aerr=%b exp lat=1 aerr=0", lat, ae); end
    access(1, 1'b0, 4'h0, 32'h8, 32'h0, lat, ld, ae, bs);
    checks++; if (ld !== 32'h0BADCAFE) begin failures++; $display("FAIL w0_mask0_unchanged got=%h exp=0badcafe", ld); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_mask();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_access();
    test_wait0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
